// File: rtl/sr_latch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sr_latch_pkg
//  Description : Shared command encoding and next-state rule for the clocked
//                SR storage element.
//  Revision    : 1.0 - initial release
// ============================================================================
package sr_latch_pkg;

    typedef enum logic [1:0] {
        SR_HOLD    = 2'b00,
        SR_CLEAR   = 2'b01,
        SR_SET     = 2'b10,
        SR_ILLEGAL = 2'b11
    } sr_cmd_t;

    localparam logic SR_RESET_Q = 1'b0;

    // Both HOLD and ILLEGAL keep the present value, so q never oscillates or goes X.
    function automatic logic sr_next(sr_cmd_t cmd, logic q);
        logic nxt;
        nxt = q;
        case (cmd)
            SR_SET:   nxt = 1'b1;
            SR_CLEAR: nxt = 1'b0;
            default:  nxt = q;
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sr_latch_bit.sv
`default_nettype none
// ============================================================================
//  Module      : sr_latch_bit
//  Description : One edge-triggered SR bit with complement output and an
//                optional sticky illegal-command flag (SR_LATCH_ILLEGAL_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
module sr_latch_bit
    import sr_latch_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic s,
    input  logic r,
    output logic q,
    output logic qn
`ifdef SR_LATCH_ILLEGAL_EN
    ,
    output logic illegal
`endif
);

    sr_cmd_t w_cmd;
    logic    r_q;

    assign w_cmd = sr_cmd_t'({s, r});

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_q <= SR_RESET_Q;
        end else begin
            r_q <= sr_next(w_cmd, r_q);
        end
    end

    assign q  = r_q;
    assign qn = ~r_q;

`ifdef SR_LATCH_ILLEGAL_EN
    logic r_illegal;

    // Sticky: only reset clears the flag once an S=R=1 edge has been seen.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_illegal <= 1'b0;
        end else if (w_cmd == SR_ILLEGAL) begin
            r_illegal <= 1'b1;
        end
    end

    assign illegal = r_illegal;
`endif

endmodule
`default_nettype wire

// File: rtl/sr_latch_clocked.sv
`default_nettype none
// ============================================================================
//  Module      : sr_latch_clocked
//  Description : WIDTH independent clocked SR bits; optional per-bit illegal
//                flag enabled by SR_LATCH_ILLEGAL_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module sr_latch_clocked
    import sr_latch_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn
`ifdef SR_LATCH_ILLEGAL_EN
    ,
    output logic [WIDTH-1:0] illegal
`endif
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sr_latch_bit u_bit (
            .clk     (clk),
            .reset   (reset),
            .s       (s[i]),
            .r       (r[i]),
            .q       (q[i]),
            .qn      (qn[i])
`ifdef SR_LATCH_ILLEGAL_EN
            ,
            .illegal (illegal[i])
`endif
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_sr_latch_clocked.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sr_latch_clocked
//  Description : Scoreboard bench for sr_latch_clocked (WIDTH=4), directed
//                sequences followed by random s/r/reset traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_latch_clocked;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] s = '0;
    logic [W-1:0] r = '0;
    wire  [W-1:0] q;
    wire  [W-1:0] qn;
    wire  [W-1:0] illegal_w;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] ill;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] m_q   = '0;
    logic [W-1:0] m_ill = '0;

    sr_latch_clocked #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .s       (s),
        .r       (r),
        .q       (q),
        .qn      (qn)
`ifdef SR_LATCH_ILLEGAL_EN
        ,
        .illegal (illegal_w)
`endif
    );

`ifndef SR_LATCH_ILLEGAL_EN
    assign illegal_w = '0;
`endif

    always #5 clk = ~clk;

    // Reference: each bit follows the set/clear/hold rules; reset wins.
    always @(posedge clk) begin
        exp_t e;
        if (!reset) begin
            m_q   = '0;
            m_ill = '0;
        end else begin
            for (int i = 0; i < W; i++) begin
                if (s[i] && !r[i])      m_q[i] = 1'b1;
                else if (r[i] && !s[i]) m_q[i] = 1'b0;
                else if (s[i] && r[i])  m_ill[i] = 1'b1;
            end
        end
        e.q   = m_q;
        e.ill = m_ill;
        sb.push_back(e);
    end

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (q !== e.q || $isunknown(q)) begin
                    n_err++;
                    $display("FAIL q: got %b expected %b at %0t", q, e.q, $time);
                end
                n_cmp++;
                if (qn !== ~e.q || $isunknown(qn)) begin
                    n_err++;
                    $display("FAIL qn: got %b expected %b at %0t", qn, ~e.q, $time);
                end
`ifdef SR_LATCH_ILLEGAL_EN
                n_cmp++;
                if (illegal_w !== e.ill) begin
                    n_err++;
                    $display("FAIL illegal: got %b expected %b at %0t", illegal_w, e.ill, $time);
                end
`endif
            end
        end
    end

    task automatic drive(input logic rst_n, input logic [W-1:0] sv, input logic [W-1:0] rv);
        @(negedge clk);
        reset = rst_n;
        s     = sv;
        r     = rv;
    endtask

    initial begin
        // Reset held two edges with a pending SET, then released with SET.
        drive(1'b0, 4'hF, 4'h0);
        drive(1'b0, 4'hF, 4'h0);
        drive(1'b1, 4'hF, 4'h0);
        drive(1'b1, 4'h0, 4'hF);
        // Set / hold / clear / hold on bit 0.
        drive(1'b1, 4'h1, 4'h0);
        repeat (3) drive(1'b1, 4'h0, 4'h0);
        drive(1'b1, 4'h0, 4'h1);
        drive(1'b1, 4'h0, 4'h0);
        // Illegal from q=1 then clear, illegal from q=0.
        drive(1'b1, 4'h1, 4'h0);
        drive(1'b1, 4'h1, 4'h1);
        drive(1'b1, 4'h0, 4'h1);
        drive(1'b1, 4'h0, 4'h0);
        drive(1'b1, 4'h2, 4'h2);
        // Clear sticky flags, then the multi-bit pattern from q=0000.
        drive(1'b0, 4'h0, 4'h0);
        drive(1'b1, 4'b0101, 4'b0011);
        drive(1'b1, 4'h0, 4'h0);
        // Mid-operation reset while SET is still asserted.
        drive(1'b1, 4'hF, 4'h0);
        drive(1'b0, 4'hF, 4'h0);
        drive(1'b1, 4'h0, 4'h0);
        // Random traffic with occasional reset.
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 19) != 0), W'($urandom), W'($urandom));
        end
        drive(1'b1, 4'h0, 4'h0);
        @(posedge clk);
        #2;
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
